// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encoding and default sizes for the hazard controller
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 32;
    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int TO_W_DEF        = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter used for performance statistics
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high clear
//   inc_i  count this cycle
//   cnt_o  current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 run enable
//   load_use_i              load-use hazard from the hazard detection unit
//   branch_taken_i, jump_i  control-flow redirect resolved in ID
//   mem_req_i, mem_ack_i    data-memory handshake for the instruction in MEM
//   pc_write_o .. mem_stb_o per-stage enables, flushes, bubbles and memory strobe
//   fault_o                 memory timeout latched (cleared only by reset)
//   *_cnt_o                 saturating performance counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             stage_hold_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_stb_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt;
    logic            active;
    logic            freeze;
    logic            redirect;
    logic            stall_inc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign redirect = branch_taken_i | jump_i;

    always_comb begin
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        active          = 1'b0;
        freeze          = 1'b0;
        stall_inc       = 1'b0;
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b1;
        stage_hold_o    = 1'b1;
        mem_wb_bubble_o = 1'b1;
        mem_stb_o       = 1'b0;
        fault_o         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                active    = 1'b1;
                mem_stb_o = mem_req_i;
                // An access acked in its first cycle never freezes.
                freeze    = mem_req_i & ~mem_ack_i;
                wait_nxt  = '0;
                if (freeze) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (!start_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                active    = 1'b1;
                mem_stb_o = 1'b1;
                if (mem_ack_i) begin
                    // The access always completes before honouring a start_i drop.
                    wait_nxt  = '0;
                    state_nxt = start_i ? ST_RUN : ST_IDLE;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + 1'b1;
                    if (wait_nxt == TO_W'(MEM_TIMEOUT)) begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                fault_o = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Hazard priority while the pipeline is live: freeze > load-use > redirect.
        if (active) begin
            if (freeze) begin
                id_ex_bubble_o  = 1'b0;
            end else if (load_use_i) begin
                stage_hold_o    = 1'b0;
                mem_wb_bubble_o = 1'b0;
                // Stall without flush lets ID re-resolve the branch next cycle.
                stall_inc       = ~redirect;
            end else begin
                pc_write_o      = 1'b1;
                if_id_write_o   = 1'b1;
                if_id_flush_o   = redirect;
                id_ex_bubble_o  = 1'b0;
                stage_hold_o    = 1'b0;
                mem_wb_bubble_o = 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (active),        .cnt_o (cycle_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (stall_inc),     .cnt_o (stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (if_id_flush_o), .cnt_o (flush_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (freeze),        .cnt_o (memwait_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, lu, br, jmp, req, ack;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, stage_hold, mem_wb_bubble, mem_stb, fault;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt, memwait_cnt;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, stage_hold4, mem_wb_bubble4, mem_stb4, fault4;
    logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4, memwait_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i (clk), .rst_i (rst), .start_i (start), .load_use_i (lu),
        .branch_taken_i (br), .jump_i (jmp), .mem_req_i (req), .mem_ack_i (ack),
        .pc_write_o (pc_write), .if_id_write_o (if_id_write), .if_id_flush_o (if_id_flush),
        .id_ex_bubble_o (id_ex_bubble), .stage_hold_o (stage_hold), .mem_wb_bubble_o (mem_wb_bubble),
        .mem_stb_o (mem_stb), .fault_o (fault),
        .cycle_cnt_o (cycle_cnt), .stall_cnt_o (stall_cnt), .flush_cnt_o (flush_cnt), .memwait_cnt_o (memwait_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk_i (clk), .rst_i (rst), .start_i (start), .load_use_i (lu),
        .branch_taken_i (br), .jump_i (jmp), .mem_req_i (req), .mem_ack_i (ack),
        .pc_write_o (pc_write4), .if_id_write_o (if_id_write4), .if_id_flush_o (if_id_flush4),
        .id_ex_bubble_o (id_ex_bubble4), .stage_hold_o (stage_hold4), .mem_wb_bubble_o (mem_wb_bubble4),
        .mem_stb_o (mem_stb4), .fault_o (fault4),
        .cycle_cnt_o (cycle_cnt4), .stall_cnt_o (stall_cnt4), .flush_cnt_o (flush_cnt4), .memwait_cnt_o (memwait_cnt4)
    );

    // Inputs change just after a negedge; combinational outputs are sampled #1 later.
    task automatic set_in(input logic l, input logic b, input logic j, input logic r, input logic a);
        lu = l; br = b; jmp = j; req = r; ack = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the DUT in RUN, just after a negedge.
    task automatic go_run();
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if ({pc_write, if_id_write, stage_hold, id_ex_bubble, mem_wb_bubble, if_id_flush, mem_stb, fault} !== 8'b0011_1000) begin
            errors++; $display("FAIL reset_outputs got %b exp %b", {pc_write, if_id_write, stage_hold, id_ex_bubble, mem_wb_bubble, if_id_flush, mem_stb, fault}, 8'b0011_1000);
        end
        checks++; if ({cycle_cnt, stall_cnt, flush_cnt, memwait_cnt} !== 128'd0) begin
            errors++; $display("FAIL reset_counters got %0d %0d %0d %0d exp 0", cycle_cnt, stall_cnt, flush_cnt, memwait_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (pc_write !== 1'b0 || stage_hold !== 1'b1) begin
            errors++; $display("FAIL idle_hold got pc_write=%b stage_hold=%b exp 0 1", pc_write, stage_hold);
        end
    endtask

    task automatic test_run();
        do_reset();
        start = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin
            errors++; $display("FAIL run_start_latency got %b exp 0", pc_write);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1 || stage_hold !== 1'b0 || id_ex_bubble !== 1'b0) begin
                errors++; $display("FAIL run_default[%0d] got pc=%b ifid=%b hold=%b bub=%b exp 1 1 0 0", i, pc_write, if_id_write, stage_hold, id_ex_bubble);
            end
            @(negedge clk);
        end
        checks++; if (cycle_cnt !== 32'd10) begin
            errors++; $display("FAIL run_cycle_cnt got %0d exp 10", cycle_cnt);
        end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || memwait_cnt !== 32'd0) begin
            errors++; $display("FAIL run_other_cnt got %0d %0d %0d exp 0 0 0", stall_cnt, flush_cnt, memwait_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        go_run();
        for (int i = 0; i < 4; i++) begin
            set_in((i % 2) == 0, 0, 0, 0, 0);
            #1;
            if ((i % 2) == 0) begin
                checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
                    errors++; $display("FAIL lu_stall[%0d] got pc=%b ifid=%b bub=%b exp 0 0 1", i, pc_write, if_id_write, id_ex_bubble);
                end
            end else begin
                checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
                    errors++; $display("FAIL lu_release[%0d] got pc=%b bub=%b exp 1 0", i, pc_write, id_ex_bubble);
                end
            end
            @(negedge clk);
        end
        checks++; if (stall_cnt !== 32'd2 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL lu_counts got stall=%0d flush=%0d exp 2 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_lu_branch();
        do_reset();
        go_run();
        set_in(1, 1, 0, 0, 0);
        #1;
        checks++; if (if_id_flush !== 1'b0 || pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
            errors++; $display("FAIL lubr_stall got flush=%b pc=%b bub=%b exp 0 0 1", if_id_flush, pc_write, id_ex_bubble);
        end
        @(negedge clk);
        set_in(0, 1, 0, 0, 0);
        #1;
        checks++; if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin
            errors++; $display("FAIL lubr_flush got flush=%b pc=%b exp 1 1", if_id_flush, pc_write);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
            errors++; $display("FAIL lubr_counts got stall=%0d flush=%0d exp 0 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        int stb_cycles;
        do_reset();
        go_run();
        // Zero-wait access: strobe but no freeze.
        set_in(0, 0, 0, 1, 1);
        #1;
        checks++; if (mem_stb !== 1'b1 || pc_write !== 1'b1 || stage_hold !== 1'b0) begin
            errors++; $display("FAIL mem_zero_wait got stb=%b pc=%b hold=%b exp 1 1 0", mem_stb, pc_write, stage_hold);
        end
        @(negedge clk);
        stb_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 1, 0);
            #1;
            if (mem_stb === 1'b1) stb_cycles++;
            checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || stage_hold !== 1'b1 || mem_wb_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
                errors++; $display("FAIL mem_freeze[%0d] got pc=%b ifid=%b hold=%b wbb=%b flush=%b exp 0 0 1 1 0", i, pc_write, if_id_write, stage_hold, mem_wb_bubble, if_id_flush);
            end
            @(negedge clk);
        end
        set_in(0, 0, 1, 1, 1);
        #1;
        if (mem_stb === 1'b1) stb_cycles++;
        checks++; if (pc_write !== 1'b1 || stage_hold !== 1'b0 || if_id_flush !== 1'b1) begin
            errors++; $display("FAIL mem_release got pc=%b hold=%b flush=%b exp 1 0 1", pc_write, stage_hold, if_id_flush);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (mem_stb !== 1'b0 || pc_write !== 1'b1) begin
            errors++; $display("FAIL mem_after got stb=%b pc=%b exp 0 1", mem_stb, pc_write);
        end
        checks++; if (stb_cycles !== 4) begin
            errors++; $display("FAIL mem_stb_cycles got %0d exp 4", stb_cycles);
        end
        checks++; if (memwait_cnt !== 32'd3 || flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL mem_counts got memwait=%0d flush=%0d stall=%0d exp 3 1 0", memwait_cnt, flush_cnt, stall_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_start_drop();
        do_reset();
        go_run();
        set_in(0, 0, 0, 1, 0);
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_stb !== 1'b1 || stage_hold !== 1'b1) begin
            errors++; $display("FAIL drop_wait got stb=%b hold=%b exp 1 1", mem_stb, stage_hold);
        end
        set_in(0, 0, 0, 1, 1);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (pc_write !== 1'b0 || stage_hold !== 1'b1 || mem_stb !== 1'b0 || id_ex_bubble !== 1'b1) begin
            errors++; $display("FAIL drop_idle got pc=%b hold=%b stb=%b bub=%b exp 0 1 0 1", pc_write, stage_hold, mem_stb, id_ex_bubble);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        go_run();
        set_in(0, 0, 0, 1, 0);
        // One RUN freeze cycle, then 16 un-acked MEM_WAIT cycles.
        for (int i = 0; i < 17; i++) begin
            #1;
            checks++; if (fault !== 1'b0 || mem_stb !== 1'b1) begin
                errors++; $display("FAIL to_waiting[%0d] got fault=%b stb=%b exp 0 1", i, fault, mem_stb);
            end
            @(negedge clk);
        end
        #1;
        checks++; if (fault !== 1'b1 || pc_write !== 1'b0 || mem_stb !== 1'b0 || stage_hold !== 1'b1) begin
            errors++; $display("FAIL to_fault got fault=%b pc=%b stb=%b hold=%b exp 1 0 0 1", fault, pc_write, mem_stb, stage_hold);
        end
        checks++; if (memwait_cnt !== 32'd17 || cycle_cnt !== 32'd17) begin
            errors++; $display("FAIL to_counts got memwait=%0d cycle=%0d exp 17 17", memwait_cnt, cycle_cnt);
        end
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        checks++; if (fault !== 1'b1) begin
            errors++; $display("FAIL to_sticky got %b exp 1", fault);
        end
        rst = 1'b1;
        #1;
        checks++; if (fault !== 1'b0 || cycle_cnt !== 32'd0 || memwait_cnt !== 32'd0) begin
            errors++; $display("FAIL to_reset got fault=%b cycle=%0d memwait=%0d exp 0 0 0", fault, cycle_cnt, memwait_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        go_run();
        set_in(0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_stb !== 1'b0 || pc_write !== 1'b0 || memwait_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL async_rst got stb=%b pc=%b memwait=%0d cycle=%0d exp 0 0 0 0", mem_stb, pc_write, memwait_cnt, cycle_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        go_run();
        set_in(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                checks++; if (flush_cnt4 !== 4'd15) begin
                    errors++; $display("FAIL sat_reach got %0d exp 15", flush_cnt4);
                end
            end
            @(negedge clk);
        end
        checks++; if (flush_cnt4 !== 4'd15 || cycle_cnt4 !== 4'd15) begin
            errors++; $display("FAIL sat_hold got flush=%0d cycle=%0d exp 15 15", flush_cnt4, cycle_cnt4);
        end
        checks++; if (flush_cnt !== 32'd20) begin
            errors++; $display("FAIL sat_wide got %0d exp 20", flush_cnt);
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        lu = 1'b0; br = 1'b0; jmp = 1'b0; req = 1'b0; ack = 1'b0;
        test_reset();
        test_run();
        test_load_use();
        test_lu_branch();
        test_mem_wait();
        test_start_drop();
        test_timeout();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
